usr_serial_rx: RTL

//   Serial-to-parallel frame receiver: the far end of the universal shift register's serial outputs.

---
 rtl/usr_serial_rx.sv | 114 +++++++++++
 1 files changed

// File: rtl/usr_serial_rx.sv
// Serial-to-parallel frame receiver: collects WIDTH bits, MSB- or LSB-first per frame,
// and presents the assembled word on a valid/ready handshake.
module usr_serial_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic             s_din_i,
  input  logic             s_valid_i,
  output logic [WIDTH-1:0] p_dout_o,
  output logic             p_valid_o,
  input  logic             p_ready_i,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dir_q, dir_d;
  logic             ovr_q, ovr_d;
  logic             pvalid_q, pvalid_d;
  logic [WIDTH-1:0] shifted;

  // dir_q=1 shifts toward the MSB so the first bit ends up on top.
  assign shifted = dir_q ? {sr_q[WIDTH-2:0], s_din_i} : {s_din_i, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    dout_d   = dout_q;
    dir_d    = dir_q;
    ovr_d    = ovr_q;
    pvalid_d = pvalid_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRecv;
          dir_d   = dir_i;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      StRecv: begin
        if (start_i) begin
          // Restart drops the partial frame and this cycle's bit.
          dir_d = dir_i;
          cnt_d = '0;
          ovr_d = 1'b0;
        end else if (s_valid_i) begin
          sr_d = shifted;
          if (cnt_q == CntLast) begin
            dout_d   = shifted;
            pvalid_d = 1'b1;
            cnt_d    = '0;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (s_valid_i) ovr_d = 1'b1;
        if (p_ready_i) begin
          pvalid_d = 1'b0;
          if (start_i) begin
            state_d = StRecv;
            dir_d   = dir_i;
            cnt_d   = '0;
            ovr_d   = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sr_q     <= '0;
      dout_q   <= '0;
      dir_q    <= 1'b0;
      ovr_q    <= 1'b0;
      pvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      dout_q   <= dout_d;
      dir_q    <= dir_d;
      ovr_q    <= ovr_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign p_dout_o  = dout_q;
  assign p_valid_o = pvalid_q;
  assign busy_o    = (state_q == StRecv);
  assign overrun_o = ovr_q;

endmodule
